// File: rtl/latch_arbiter_pkg.sv
// Shared types and helpers for the latch arbiter: FSM state encoding and
// the wrapping round-robin pointer advance.
package latch_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   function automatic int next_ptr(input int cur, input int n);
      return (cur + 1 >= n) ? 0 : cur + 1;
   endfunction

endpackage

// File: rtl/latch_arbiter_if.sv
// Requester/consumer bundle for the latch arbiter; the arbiter side uses
// the slave modport, producers and the consumer use master.
interface latch_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 16
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] req_data;
   logic [N_REQ-1:0]       rel;
   logic [N_REQ-1:0]       gnt;
   logic [WIDTH-1:0]       out;
   logic                   out_valid;
   logic [IDX_W-1:0]       owner;
   logic                   busy;
   logic                   timeout;

   modport master (
      output req, req_data, rel,
      input  gnt, out, out_valid, owner, busy, timeout
   );

   modport slave (
      input  req, req_data, rel,
      output gnt, out, out_valid, owner, busy, timeout
   );

endinterface

// File: rtl/latch_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping at N_REQ. Reusable by any arbiter.
module latch_arbiter_rr_pick #(
   parameter  int N_REQ = 4,
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx,
   output logic [N_REQ-1:0] onehot
);

   always_comb begin
      any    = 1'b0;
      idx    = '0;
      onehot = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!any && req[(int'(ptr) + k) % N_REQ]) begin
            any = 1'b1;
            idx = IDX_W'((int'(ptr) + k) % N_REQ);
         end
      end
      if (any) onehot = N_REQ'(1) << idx;
   end

endmodule

// File: rtl/latch_arbiter.sv
// Round-robin owned hold register with zero-latency bypass: the winner's
// data appears on out in the grant cycle and is held until release/timeout.
module latch_arbiter
   import latch_arbiter_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int WIDTH       = 16,
   parameter int HOLD_CYCLES = 8
) (
   input  logic           clk,
   input  logic           rst,
   latch_arbiter_if.slave bus
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [WIDTH-1:0] hold_buf_q, hold_buf_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;
   logic [N_REQ-1:0] pick_onehot;
   logic [WIDTH-1:0] pick_data, own_data;
   logic             own_req, own_rel, expire;

   logic [N_REQ-1:0] gnt_c;
   logic [WIDTH-1:0] out_c;
   logic             valid_c, busy_c, timeout_c;
   logic [IDX_W-1:0] owner_c;

   latch_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req    (bus.req),
      .ptr    (rr_ptr_q),
      .any    (pick_any),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   assign pick_data = bus.req_data[int'(pick_idx) * WIDTH +: WIDTH];
   assign own_data  = bus.req_data[int'(owner_q) * WIDTH +: WIDTH];
   assign own_req   = bus.req[owner_q];
   assign own_rel   = bus.rel[owner_q];
   assign expire    = (HOLD_CYCLES != 0) && (hold_cnt_q == CNT_W'(1));

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      hold_buf_d = hold_buf_q;
      hold_cnt_d = hold_cnt_q;
      gnt_c      = '0;
      out_c      = hold_buf_q;
      valid_c    = 1'b0;
      owner_c    = owner_q;
      busy_c     = 1'b0;
      timeout_c  = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_any) begin
               gnt_c      = pick_onehot;
               out_c      = pick_data;
               valid_c    = 1'b1;
               owner_c    = pick_idx;
               state_d    = HOLD;
               hold_buf_d = pick_data;
               owner_d    = pick_idx;
               hold_cnt_d = CNT_W'(HOLD_CYCLES);
            end
         end
         HOLD: begin
            gnt_c   = N_REQ'(1) << owner_q;
            out_c   = own_req ? own_data : hold_buf_q;
            valid_c = 1'b1;
            busy_c  = 1'b1;
            if (HOLD_CYCLES != 0) hold_cnt_d = hold_cnt_q - CNT_W'(1);
            // Release wins over a same-cycle owner update: bypass only, no capture.
            if (own_rel || expire) begin
               state_d   = IDLE;
               rr_ptr_d  = IDX_W'(next_ptr(int'(owner_q), N_REQ));
               timeout_c = expire && !own_rel;
            end else if (own_req) begin
               hold_buf_d = own_data;
            end
         end
         default: state_d = IDLE;
      endcase

      if (rst) begin
         gnt_c     = '0;
         out_c     = '0;
         valid_c   = 1'b0;
         owner_c   = '0;
         busy_c    = 1'b0;
         timeout_c = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         hold_buf_q <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         hold_buf_q <= hold_buf_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign bus.gnt       = gnt_c;
   assign bus.out       = out_c;
   assign bus.out_valid = valid_c;
   assign bus.owner     = owner_c;
   assign bus.busy      = busy_c;
   assign bus.timeout   = timeout_c;

endmodule

// File: tb/tb_latch_arbiter.sv
// Randomized and directed bench for latch_arbiter against a cycle-level
// behavioural model of ownership, hold and release.
module tb_latch_arbiter;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int HC = 8;

   logic clk;
   logic rst;

   latch_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

   latch_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_CYCLES(HC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // model state: who owns the register, for how many more cycles
   bit             m_hold  = 0;
   int             m_owner = 0;
   int             m_ptr   = 0;
   int             m_left  = 0;
   logic [W-1:0]   m_buf   = '0;

   logic [N-1:0]   cap_gnt;
   logic [W-1:0]   cap_out;
   int             cap_owner;
   logic           cap_busy, cap_to, cap_vld;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [N*W-1:0] rdat();
      logic [N*W-1:0] r;
      for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
      return r;
   endfunction

   task automatic step(input logic r, input logic [N-1:0] rq,
                       input logic [N*W-1:0] dat, input logic [N-1:0] rl);
      int           w;
      bit           rls;
      logic [N-1:0] e_gnt;
      logic [W-1:0] e_out, d_w, d_o;
      logic         e_vld, e_busy, e_to;
      int           e_own;
      rst          = r;
      bus.req      = rq;
      bus.req_data = dat;
      bus.rel      = rl;
      w = -1;
      if (!m_hold)
         for (int k = 0; k < N; k++)
            if (w < 0 && rq[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      d_o = dat[m_owner*W +: W];
      d_w = (w >= 0) ? dat[w*W +: W] : '0;
      rls = m_hold && (rl[m_owner] || (HC != 0 && m_left == 1));
      e_gnt = '0; e_out = m_buf; e_vld = 0; e_own = m_owner; e_busy = 0; e_to = 0;
      if (r) begin
         e_out = '0; e_own = 0;
      end else if (m_hold) begin
         e_gnt  = N'(1) << m_owner;
         e_out  = rq[m_owner] ? d_o : m_buf;
         e_vld  = 1; e_busy = 1;
         e_to   = rls && !rl[m_owner];
      end else if (w >= 0) begin
         e_gnt = N'(1) << w; e_out = d_w; e_vld = 1; e_own = w;
      end

      @(negedge clk);
      cap_gnt = bus.gnt; cap_out = bus.out; cap_owner = int'(bus.owner);
      cap_busy = bus.busy; cap_to = bus.timeout; cap_vld = bus.out_valid;
      chk("gnt",       32'(cap_gnt),   32'(e_gnt));
      chk("out",       32'(cap_out),   32'(e_out));
      chk("out_valid", 32'(cap_vld),   32'(e_vld));
      chk("owner",     32'(cap_owner), 32'(e_own));
      chk("busy",      32'(cap_busy),  32'(e_busy));
      chk("timeout",   32'(cap_to),    32'(e_to));

      @(posedge clk);
      if (r) begin
         m_hold = 0; m_ptr = 0; m_buf = '0; m_left = 0; m_owner = 0;
      end else if (m_hold) begin
         if (rls) begin
            m_hold = 0; m_ptr = (m_owner + 1) % N;
         end else begin
            if (rq[m_owner]) m_buf = d_o;
            if (HC != 0) m_left--;
         end
      end else if (w >= 0) begin
         m_hold = 1; m_owner = w; m_buf = d_w; m_left = HC;
      end
      #1;
   endtask

   initial begin
      logic [N*W-1:0] dat;
      rst = 1'b1; bus.req = '0; bus.req_data = '0; bus.rel = '0;

      // reset with all requests asserted, then quiet idle
      step(1, 4'b1111, rdat(), '0);
      chk("rst_gnt", 32'(cap_gnt), 32'd0);
      step(1, 4'b1111, rdat(), '0);
      chk("rst_out", 32'(cap_out), 32'd0);
      step(0, '0, rdat(), '0);
      step(0, '0, rdat(), '0);
      chk("idle_out", 32'(cap_out), 32'd0);

      // zero-latency grant and hold
      dat = rdat(); dat[2*W +: W] = 16'hBEEF;
      step(0, 4'b0100, dat, '0);
      chk("zl_out", 32'(cap_out), 32'hBEEF);
      chk("zl_owner", 32'(cap_owner), 32'd2);
      chk("zl_gnt", 32'(cap_gnt), 32'b0100);
      step(0, '0, rdat(), '0);
      chk("zl_hold", 32'(cap_out), 32'hBEEF);
      chk("zl_busy", 32'(cap_busy), 32'd1);
      step(0, '0, rdat(), 4'b0100);
      step(0, '0, rdat(), '0);

      // round-robin order 0,1,2,3,0
      step(1, '0, rdat(), '0);
      for (int k = 0; k < 5; k++) begin
         step(0, 4'b1111, rdat(), '0);
         chk("rr_order", 32'(cap_owner), 32'(k % N));
         step(0, 4'b1111, rdat(), '0);
         step(0, 4'b1111, rdat(), N'(1) << (k % N));
      end

      // timeout after HC hold cycles
      step(1, '0, rdat(), '0);
      step(0, 4'b0010, rdat(), '0);
      for (int i = 1; i <= HC; i++) begin
         step(0, '0, rdat(), '0);
         if (i == HC - 1) chk("to_early", 32'(cap_to), 32'd0);
         if (i == HC)     chk("to_pulse", 32'(cap_to), 32'd1);
      end
      step(0, '0, rdat(), '0);
      chk("to_busy", 32'(cap_busy), 32'd0);
      step(0, 4'b1111, rdat(), '0);
      chk("to_ptr", 32'(cap_owner), 32'd2);

      // owner update, then update together with release
      step(1, '0, rdat(), '0);
      dat = rdat(); dat[0 +: W] = 16'hAAAA;
      step(0, 4'b0001, dat, '0);
      dat[0 +: W] = 16'h1234;
      step(0, 4'b0001, dat, '0);
      chk("upd_bypass", 32'(cap_out), 32'h1234);
      step(0, '0, rdat(), '0);
      chk("upd_held", 32'(cap_out), 32'h1234);
      dat = rdat(); dat[0 +: W] = 16'h5678;
      step(0, 4'b0001, dat, 4'b0001);
      chk("rel_bypass", 32'(cap_out), 32'h5678);
      step(0, '0, rdat(), '0);
      chk("rel_busy", 32'(cap_busy), 32'd0);
      chk("rel_nowrite", 32'(cap_out), 32'h1234);

      // reset in the middle of a hold
      step(0, 4'b0100, rdat(), '0);
      step(0, '0, rdat(), '0);
      step(1, '0, rdat(), '0);
      step(0, '0, rdat(), '0);
      chk("mid_rst_out", 32'(cap_out), 32'd0);
      chk("mid_rst_vld", 32'(cap_vld), 32'd0);
      step(0, 4'b1111, rdat(), '0);
      chk("mid_rst_ptr", 32'(cap_owner), 32'd0);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         logic [N-1:0] rq, rl;
         rq = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
         rl = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         step(($urandom_range(0, 99) == 0), rq, rdat(), rl);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/latch_arbiter.md
Name: latch_arbiter

Overview:
- Shares one zero-latency hold register ("soft latch" datapath) between N_REQ requesters.
- A round-robin arbiter grants ownership of the register. In the grant cycle the winner's data passes straight to `out` combinationally and is captured at the same edge.
- The owner holds the value until it releases, or until a hold-timeout counter expires.
- Sits between several producers and a single downstream consumer that needs a stable held value.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- WIDTH, 16, data width in bits
- HOLD_CYCLES, 8, maximum HOLD cycles before forced release; 0 = no timeout
- IDX_W, $clog2(N_REQ), owner index width (derived, not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  N_REQ  per-requester request / latch strobe
- req_data  in  N_REQ*WIDTH  packed requester data; requester i occupies [i*WIDTH +: WIDTH]
- rel  in  N_REQ  per-requester release strobe
- gnt  out  N_REQ  one-hot grant; all zero when no owner
- out  out  WIDTH  held or bypassed data
- out_valid  out  1  out carries owner data
- owner  out  IDX_W  index of the current/granting requester
- busy  out  1  FSM is in HOLD
- timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (rst=1 at a clock edge), applies from any state including mid-HOLD:
  - state=IDLE, rr_ptr=0, hold_buf=0, hold_cnt=0, owner_q=0.
  - All outputs read 0 during the cycle after reset and until the next grant.
  - While rst=1, gnt, out and out_valid are forced to 0 combinationally, so bypass never leaks.
- FSM states: IDLE, HOLD.
- IDLE, no req: gnt=0, out=hold_buf (last held value), out_valid=0, owner=owner_q.
- IDLE, any req:
  - Winner = first set bit of req scanning upward from rr_ptr, wrapping at N_REQ.
  - Same cycle, zero latency: gnt=onehot(winner), out=req_data[winner], out_valid=1, owner=winner.
  - At the edge: hold_buf<=req_data[winner], owner_q<=winner, hold_cnt<=HOLD_CYCLES, state<=HOLD.
- HOLD:
  - gnt=onehot(owner_q), owner=owner_q, busy=1, out_valid=1.
  - out = req[owner_q] ? req_data[owner_q] : hold_buf, i.e. combinational bypass for an owner update.
  - Owner update (req[owner_q]=1): hold_buf updates at the edge; hold_cnt is not reloaded.
  - req from non-owners is ignored, with no queuing inside the block.
  - If HOLD_CYCLES!=0, hold_cnt decrements every HOLD cycle.
- Release from HOLD, when rel[owner_q]=1 or (HOLD_CYCLES!=0 and hold_cnt==1):
  - state<=IDLE, rr_ptr<=(owner_q+1) mod N_REQ.
  - Release takes priority: an owner update in the release cycle still bypasses to out in that cycle, but hold_buf is not written.
  - timeout=1 for that cycle only if the release was counter-forced and rel[owner_q]=0.
- Release cycle outputs: gnt and out_valid stay 1 during it; they drop the cycle after.
- Re-arbitration takes one IDLE cycle; back-to-back grants are therefore at best every other cycle pair (HOLD length >=1).
- rel from a non-owner, or any rel in IDLE, has no effect.
- Counter width: $clog2(HOLD_CYCLES+1), min 1. The owner is guaranteed HOLD_CYCLES cycles in HOLD.
- rr_ptr wraps N_REQ-1 -> 0.
- Every requester is granted within N_REQ arbitration rounds, which bounds starvation.

Decomposition:
- Package latch_arbiter_pkg:
  - state enum (IDLE, HOLD), 1-bit encoding
  - function for the wrapping next-pointer computation
- Sub-module rr_pick:
  - purely combinational round-robin picker
  - inputs: req[N_REQ], ptr[IDX_W]
  - outputs: any, idx[IDX_W], onehot[N_REQ]
  - parameterised by N_REQ and reusable by other arbiters

Test Plan:
- Reset/idle: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, out=0, out_valid=0, busy=0 throughout. Then rst=0, no req -> outputs stay 0.
- Zero-latency grant: idle, req=4'b0100 with data2=16'hBEEF -> same cycle gnt=4'b0100, out=16'hBEEF, owner=2. req drops next cycle -> out stays 16'hBEEF, busy=1.
- Round-robin: req=4'b1111 held, rel pulsed by each owner after 2 HOLD cycles -> grant order 0,1,2,3,0. A fifth owner=0 confirms wrap.
- Timeout: HOLD_CYCLES=8, owner never releases -> timeout pulse exactly 8 cycles after grant, busy=0 next cycle, rr_ptr advanced.
- Owner update vs. release: in HOLD, owner drives req with 16'h1234 -> out=16'h1234 same cycle, held after. The same update together with rel -> out=16'h5678 bypassed, hold_buf unchanged.
- Mid-HOLD reset: rst=1 during HOLD -> next cycle IDLE, all outputs 0, next grant starts scanning from requester 0.
